pattern_sequencer: RTL and testbench

Frame-synchronous controller that selects which test pattern the video pattern generator displays. It debounces raw user buttons once per frame and steps a pattern index with wrap-around. Index changes are committed only in the vertical blanking interval, so no pattern switch tears mid-frame. It sits between the input/OSD layer and the timing/pattern generator and consumes that generator's VBlank.

---
 rtl/pattern_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-synchronous selector for the test-pattern index.
// Raw buttons are synchronized and debounced once per frame. The index steps
// with wrap-around and is only committed in the cycles right after the VBlank
// rise, so a pattern never switches mid-frame.
// Optional auto-cycle mode is compiled in by defining PATSEQ_AUTOCYCLE_EN.
module pattern_sequencer #(
  parameter int NUM_PATTERNS    = 6,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_auto,
  output logic [3:0] pattern_sel,
  output logic       pattern_load,
  output logic       frame_tick,
  output logic       auto_active
);

`ifdef PATSEQ_AUTOCYCLE_EN
  localparam int NUM_BTN = 3;
`else
  localparam int NUM_BTN = 2;
`endif
  localparam logic [3:0] LAST_IDX  = 4'(NUM_PATTERNS - 1);
  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_LOAD} state_t;

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_press;   // press event registered in the tick cycle, held for EVAL
  logic [NUM_BTN-1:0] w_rise;    // press event being detected in the tick cycle itself
  logic               w_auto_step;

  logic r_vb_meta, r_vb_sync, r_vb_prev, r_frame_tick;
  logic [3:0] r_pattern_sel;
  state_t r_state, w_state_next;
  logic w_change;
  logic [3:0] w_new_idx;

`ifdef PATSEQ_AUTOCYCLE_EN
  assign w_btn_raw = {btn_auto, btn_prev, btn_next};
`else
  // Auto button has no function in this build.
  logic w_btn_auto_unused;
  assign w_btn_auto_unused = btn_auto;
  localparam int auto_frames_unused = AUTO_FRAMES;
  assign w_btn_raw = {btn_prev, btn_next};
`endif

  // VBlank synchronizer and rising-edge detector producing the frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vb_meta    <= 1'b0;
      r_vb_sync    <= 1'b0;
      r_vb_prev    <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vb_meta    <= vblank;
      r_vb_sync    <= r_vb_meta;
      r_vb_prev    <= r_vb_sync;
      r_frame_tick <= r_vb_sync & ~r_vb_prev;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic       r_meta, r_sync, r_stable, r_press;
      logic [3:0] r_cnt;
      logic       w_differs, w_accept;

      assign w_differs = r_sync ^ r_stable;
      // The level change is accepted once enough consecutive frames disagree.
      assign w_accept  = w_differs && ((r_cnt + 4'd1) == DEB_LIMIT);

      // Two-flop synchronizer for the raw button
      always_ff @(posedge clk) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= w_btn_raw[gi];
          r_sync <= r_meta;
        end
      end

      // Per-frame debounce; a press is a stable 0->1 transition only
      always_ff @(posedge clk) begin
        if (reset) begin
          r_stable <= 1'b0;
          r_cnt    <= 4'd0;
          r_press  <= 1'b0;
        end else if (r_frame_tick) begin
          r_press <= w_accept & r_sync;
          if (w_accept) begin
            r_stable <= r_sync;
            r_cnt    <= 4'd0;
          end else if (w_differs) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_cnt <= 4'd0;
          end
        end
      end

      assign w_press[gi] = r_press;
      assign w_rise[gi]  = r_frame_tick & w_accept & r_sync;
    end
  endgenerate

`ifdef PATSEQ_AUTOCYCLE_EN
  localparam logic [9:0] AUTO_LAST = 10'(AUTO_FRAMES - 1);
  logic [9:0] r_auto_cnt;
  logic       r_auto_on, r_auto_step;
  logic       w_manual;

  assign w_manual = w_rise[0] | w_rise[1];

  // Auto-cycle mode toggle and frame counter; the step flag is held for EVAL
  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto_on   <= 1'b0;
      r_auto_cnt  <= 10'd0;
      r_auto_step <= 1'b0;
    end else if (r_frame_tick) begin
      r_auto_step <= 1'b0;
      if (w_rise[2]) begin
        r_auto_on  <= ~r_auto_on;
        r_auto_cnt <= 10'd0;
      end else if (r_auto_on) begin
        r_auto_step <= (r_auto_cnt == AUTO_LAST);
        r_auto_cnt  <= ((r_auto_cnt == AUTO_LAST) || w_manual) ? 10'd0 : r_auto_cnt + 10'd1;
      end else if (w_manual) begin
        r_auto_cnt <= 10'd0;
      end
    end
  end

  assign w_auto_step = r_auto_step;
  assign auto_active = r_auto_on;
`else
  assign w_auto_step = 1'b0;
  assign auto_active = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state and the index decision made in EVAL
  always_comb begin
    w_state_next = r_state;
    w_change     = 1'b0;
    w_new_idx    = r_pattern_sel;
    if (w_press[0] && w_press[1]) begin
      // Simultaneous next and prev cancel, including any auto step.
      w_change = 1'b0;
    end else if (w_press[1]) begin
      w_change  = 1'b1;
      w_new_idx = (r_pattern_sel == 4'd0) ? LAST_IDX : r_pattern_sel - 4'd1;
    end else if (w_press[0] || w_auto_step) begin
      w_change  = 1'b1;
      w_new_idx = (r_pattern_sel == LAST_IDX) ? 4'd0 : r_pattern_sel + 4'd1;
    end
    case (r_state)
      ST_IDLE: if (r_frame_tick) w_state_next = ST_EVAL;
      ST_EVAL: w_state_next = w_change ? ST_LOAD : ST_IDLE;
      ST_LOAD: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Pattern index is committed only on the EVAL->LOAD transition
  always_ff @(posedge clk) begin
    if (reset)                              r_pattern_sel <= 4'd0;
    else if (r_state == ST_EVAL && w_change) r_pattern_sel <= w_new_idx;
  end

  assign pattern_sel  = r_pattern_sel;
  assign pattern_load = (r_state == ST_LOAD);
  assign frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: frame-level reference model feeding a queue of
// expected indices; a monitor pops one entry per pattern_load pulse.
module tb_pattern_sequencer;
  localparam int NP   = 6;
  localparam int DEB  = 2;
  localparam int AUTO = 4;
`ifdef PATSEQ_AUTOCYCLE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic       clk, reset, vblank, btn_next, btn_prev, btn_auto;
  logic [3:0] pattern_sel;
  logic       pattern_load, frame_tick, auto_active;

  pattern_sequencer #(.NUM_PATTERNS(NP), .DEBOUNCE_FRAMES(DEB), .AUTO_FRAMES(AUTO)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .btn_next(btn_next),
    .btn_prev(btn_prev), .btn_auto(btn_auto), .pattern_sel(pattern_sel),
    .pattern_load(pattern_load), .frame_tick(frame_tick), .auto_active(auto_active)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_tick_cyc = -100;
  int tick_cnt = 0, exp_ticks = 0, load_cnt = 0;
  int exp_q[$];

  // Frame-level model state
  int m_idx, m_afc;
  bit m_auto;
  bit m_stable[3];
  int m_run[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_idx = 0; m_afc = 0; m_auto = 0;
    for (int b = 0; b < 3; b++) begin
      m_stable[b] = 0;
      m_run[b]    = 0;
    end
    exp_q.delete();
  endtask

  // One frame of the model: debounce by counting disagreeing frames, then step.
  task automatic model_frame(input logic nx, input logic pv, input logic au);
    bit [2:0] s;
    bit [2:0] ev;
    bit astep;
    s = {au, pv, nx};
    ev = 3'b000;
    astep = 0;
    exp_ticks++;
    for (int b = 0; b < NB; b++) begin
      if (s[b] != m_stable[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_stable[b] = s[b];
          m_run[b]    = 0;
          ev[b]       = s[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
`ifdef PATSEQ_AUTOCYCLE_EN
    if (ev[2]) begin
      m_auto = !m_auto;
      m_afc  = 0;
    end else if (m_auto) begin
      m_afc++;
      if (m_afc == AUTO) begin
        astep = 1;
        m_afc = 0;
      end else if (ev[0] || ev[1]) begin
        m_afc = 0;
      end
    end
`endif
    if (ev[0] && ev[1]) begin
      // cancelled
    end else if (ev[1]) begin
      m_idx = (m_idx + NP - 1) % NP;
      exp_q.push_back(m_idx);
    end else if (ev[0] || astep) begin
      m_idx = (m_idx + 1) % NP;
      exp_q.push_back(m_idx);
    end
  endtask

  // One video frame with the buttons held at the given levels throughout
  task automatic frame(input logic nx, input logic pv, input logic au);
    btn_next = nx; btn_prev = pv; btn_auto = au;
    step(5);
    vblank = 1'b1;
    model_frame(nx, pv, au);
    step(5);
    vblank = 1'b0;
    step(4);
    check("frame_sel", pattern_sel, m_idx);
    check("frame_auto", auto_active, m_auto);
  endtask

  task automatic reset_dut();
    reset = 1'b1; vblank = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
    step(3);
    reset = 1'b0;
    model_clear();
    step(2);
  endtask

  // Monitor: every pattern_load must match the next queued expectation, 2 cycles after a tick
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_tick) begin
        tick_cnt++;
        last_tick_cyc = cyc;
      end
      if (pattern_load) begin
        load_cnt++;
        check("load_latency", cyc - last_tick_cyc, 2);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load: got load with sel=%0d required no load", pattern_sel);
        end else begin
          check("load_sel", pattern_sel, exp_q.pop_front());
        end
        $display("load %0d: cycle %0d sel=%0d", load_cnt, cyc, pattern_sel);
      end
    end
  end

  initial begin
    bit got;
    logic nx, pv, au;
    reset = 1'b1; vblank = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_auto = 1'b0;
    model_clear();
    step(3);
    check("rst_sel", pattern_sel, 0);
    check("rst_load", pattern_load, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_auto", auto_active, 0);
    reset = 1'b0;
    step(2);

    // Free-running frames, no buttons
    repeat (3) frame(0, 0, 0);
    check("idle_ticks", tick_cnt, exp_ticks);

    // Held next across 5 frames: single step on the 2nd tick
    repeat (5) frame(1, 0, 0);
    repeat (3) frame(0, 0, 0);
    check("held_loads", load_cnt, 1);

    // Wrap both directions from index 0
    reset_dut();
    repeat (3) frame(0, 1, 0);
    repeat (3) frame(0, 0, 0);
    repeat (3) frame(1, 0, 0);
    repeat (3) frame(0, 0, 0);

    // One-frame glitch, then simultaneous next+prev
    frame(1, 0, 0);
    repeat (3) frame(0, 0, 0);
    repeat (3) frame(1, 1, 0);
    repeat (3) frame(0, 0, 0);

    // Reset asserted while the FSM is in EVAL; vblank held high across release
    reset_dut();
    frame(1, 0, 0);
    btn_next = 1'b1;
    step(5);
    vblank = 1'b1;
    exp_ticks++;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (frame_tick) got = 1;
    end
    check("eval_tick_seen", got, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    btn_next = 1'b0;
    step(3);
    check("eval_rst_sel", pattern_sel, 0);
    check("eval_rst_load", pattern_load, 0);
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rel_tick_early", frame_tick, 0);
    @(posedge clk);
    @(negedge clk);
    check("rel_tick_3rd", frame_tick, 1);
    exp_ticks++;
    step(2);
    vblank = 1'b0;
    step(5);
    check("eval_rst_sel2", pattern_sel, 0);

`ifdef PATSEQ_AUTOCYCLE_EN
    // Auto-cycle on for several periods, then off
    repeat (3) frame(0, 0, 1);
    repeat (12) frame(0, 0, 0);
    repeat (3) frame(0, 0, 1);
    repeat (8) frame(0, 0, 0);
`endif

    // Randomized button levels, each held with probability 3/4 per frame
    nx = 0; pv = 0; au = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(3) == 0) nx = ~nx;
      if ($urandom_range(3) == 0) pv = ~pv;
`ifdef PATSEQ_AUTOCYCLE_EN
      if ($urandom_range(9) == 0) au = ~au;
`endif
      frame(nx, pv, au);
    end
    repeat (4) frame(0, 0, 0);

    check("queue_empty", exp_q.size(), 0);
    check("tick_count", tick_cnt, exp_ticks);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
